fp_int3_operand_feeder: RTL

- Serializes packed int3 weight words into one (fp16, int3) operand pair per cycle for the downstream fp16 × signed-int3 multiplier.
- Each accepted input word carries one fp16 activation and LANES two's-complement int3 weights.
- The block emits one beat per lane with valid/ready flow control, a lane index, and a last flag so the downstream accumulator can delimit words.
- Optional zero-weight skipping removes multiplies whose product is known to be zero.

---
 rtl/fp_int3_operand_feeder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fp_int3_operand_feeder.sv
// fp_int3_operand_feeder
// Takes one packed word (fp16 activation + LANES signed int3 weights) per
// handshake and emits one (fp16, int3) operand beat per lane towards the
// fp16 x int3 multiplier. Beats carry the lane index and a last flag so the
// accumulator can delimit words. With SKIP_ZERO=1, zero-weight lanes are
// dropped, but every word still yields at least one beat.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input word handshake
//   in_fp                 fp16 activation shared by all lanes of the word
//   in_weights            lane k at bits [3k+2:3k], two's-complement int3
//   in_count              valid lanes 0..in_count-1, 0 encodes LANES
//   out_valid / out_ready operand beat handshake
//   out_fp, out_int3      operand pair of the current beat
//   out_idx, out_last     lane number and final-beat-of-word flag
module fp_int3_operand_feeder #(
  parameter int LANES     = 10,
  parameter bit SKIP_ZERO = 1'b0,
  parameter int IW        = $clog2(LANES),
  parameter int CW        = $clog2(LANES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_fp,
  input  logic [3*LANES-1:0] in_weights,
  input  logic [CW-1:0]      in_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_fp,
  output logic [2:0]         out_int3,
  output logic [IW-1:0]      out_idx,
  output logic               out_last
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          last;
  } pick_t;

  // Lanes that may produce a beat: inside the valid count and, when
  // skipping, carrying a nonzero weight.
  function automatic logic [LANES-1:0] elig_mask(input logic [3*LANES-1:0] w,
                                                 input logic [CW-1:0]      cnt);
    logic [LANES-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) begin
      m[k] = (k < int'(cnt)) && (!SKIP_ZERO || (w[3*k +: 3] != 3'b000));
    end
    return m;
  endfunction

  // Lowest eligible lane at or above lo; last is set when no eligible lane
  // lies above the chosen one. An empty mask yields lane 0 with last=1,
  // which is the single beat of an all-zero word.
  function automatic pick_t pick_lane(input logic [LANES-1:0] m, input int lo);
    pick_t p;
    p.idx  = '0;
    p.last = 1'b1;
    for (int k = LANES - 1; k >= 0; k--) begin
      p.idx = (m[k] && (k >= lo)) ? IW'(k) : p.idx;
    end
    for (int k = 0; k < LANES; k++) begin
      p.last = p.last & ~(m[k] && (k > int'(p.idx)));
    end
    return p;
  endfunction

  state_t               state_r, state_next;
  logic [3*LANES-1:0]   weights_r, weights_next;
  logic [CW-1:0]        count_r, count_next;
  logic [15:0]          out_fp_r, out_fp_next;
  logic [2:0]           out_int3_r, out_int3_next;
  logic [IW-1:0]        out_idx_r, out_idx_next;
  logic                 out_last_r, out_last_next;

  logic [CW-1:0]        eff_count_s;
  logic                 accept_s;
  logic                 fire_s;
  pick_t                load_pick_s;
  pick_t                adv_pick_s;

  assign out_valid   = (state_r == EMIT);
  assign out_fp      = out_fp_r;
  assign out_int3    = out_int3_r;
  assign out_idx     = out_idx_r;
  assign out_last    = out_last_r;

  // Accepting while the last beat leaves keeps back-to-back words bubble-free.
  assign in_ready    = (state_r == IDLE) | (out_valid & out_ready & out_last_r);
  assign accept_s    = in_valid & in_ready;
  assign fire_s      = out_valid & out_ready;
  assign eff_count_s = (in_count == '0) ? CW'(LANES) : in_count;
  assign load_pick_s = pick_lane(elig_mask(in_weights, eff_count_s), 0);
  assign adv_pick_s  = pick_lane(elig_mask(weights_r, count_r), int'(out_idx_r) + 1);

  // Next-state and next-output computation.
  always_comb begin
    state_next    = state_r;
    weights_next  = weights_r;
    count_next    = count_r;
    out_fp_next   = out_fp_r;
    out_int3_next = out_int3_r;
    out_idx_next  = out_idx_r;
    out_last_next = out_last_r;

    case (state_r)
      IDLE: begin
        if (accept_s) state_next = EMIT;
        else          state_next = IDLE;
      end
      EMIT: begin
        if (accept_s)                  state_next = EMIT;
        else if (fire_s && out_last_r) state_next = IDLE;
        else                           state_next = EMIT;
      end
      default: state_next = IDLE;
    endcase

    if (accept_s) begin
      weights_next  = in_weights;
      count_next    = eff_count_s;
      out_fp_next   = in_fp;
      out_idx_next  = load_pick_s.idx;
      out_int3_next = in_weights[3*int'(load_pick_s.idx) +: 3];
      out_last_next = load_pick_s.last;
    end else if (fire_s && !out_last_r) begin
      out_idx_next  = adv_pick_s.idx;
      out_int3_next = weights_r[3*int'(adv_pick_s.idx) +: 3];
      out_last_next = adv_pick_s.last;
    end else begin
      out_idx_next  = out_idx_r;
    end
  end

  // State, held word and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      weights_r  <= '0;
      count_r    <= '0;
      out_fp_r   <= 16'h0000;
      out_int3_r <= 3'b000;
      out_idx_r  <= '0;
      out_last_r <= 1'b0;
    end else begin
      state_r    <= state_next;
      weights_r  <= weights_next;
      count_r    <= count_next;
      out_fp_r   <= out_fp_next;
      out_int3_r <= out_int3_next;
      out_idx_r  <= out_idx_next;
      out_last_r <= out_last_next;
    end
  end

endmodule
